// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and types for the OpenMips fetch-stage PC generator.
//   RstEnable          reset level (active-low reset, so 1'b0)
//   ChipEnable/Disable fetch enable levels
//   Branch/NotBranch   branch flag levels
//   InstAddrBus        default instruction address width
//   DefaultResetVector first fetch address after reset release
//   pc_state_e         PC_OFF / PC_RUN / PC_HELD state encodings
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic Branch      = 1'b1;
    localparam logic NotBranch   = 1'b0;

    localparam int InstAddrBus = 32;

    localparam logic [31:0] DefaultResetVector = 32'h8000_0000;

    typedef enum logic [1:0] {
        PC_OFF  = 2'b00,
        PC_RUN  = 2'b01,
        PC_HELD = 2'b10
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds one branch target that could not be taken because
// fetch was not advancing.
//   clk, rst            clock / asynchronous active-low reset
//   load, target        capture (or overwrite) the buffered target
//   clear               drop the buffered target (wins over load)
//   pending_addr        buffered target address
//   pending_valid       a buffered target is waiting
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pending_addr,
    output logic              pending_valid
);

    logic [ADDR_W-1:0] addr_reg;
    logic              valid_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            addr_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            addr_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            // A newer branch simply replaces any older buffered target.
            addr_reg  <= target;
            valid_reg <= 1'b1;
        end
    end

    assign pending_addr  = addr_reg;
    assign pending_valid = valid_reg;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the OpenMips fetch stage.
//   clk                      clock, rising edge
//   rst                      asynchronous active-low reset
//   stall_i                  pipeline stall vector, bit 0 stalls the PC stage
//   if_ready_i               instruction memory accepts the current fetch
//   branch_flag_i            branch taken (from ID)
//   branch_target_address_i  branch destination
//   flush_i, new_pc_i        exception/eret flush and its destination
//   pc, ce                   fetch address and fetch enable (registered)
//   redirect_pending_o       a buffered branch target is waiting
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              ADDR_W       = InstAddrBus,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DefaultResetVector,
    parameter int              INST_BYTES   = 4,
    parameter int              STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               if_ready_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending_o
);

    localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(INST_BYTES);

    pc_state_e         state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              ce_reg, ce_next;
    logic              buf_load, buf_clear;
    logic [ADDR_W-1:0] pending_addr;
    logic              pending_valid;
    logic              advance;

    // Only the PC-stage bit of the stall vector matters here.
    generate
        if (STALL_W > 1) begin : g_stall_rest
            logic stall_unused;
            assign stall_unused = ^stall_i[STALL_W-1:1];
        end
    endgenerate

    assign advance = ce_reg & ~stall_i[0] & if_ready_i;

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk           (clk),
        .rst           (rst),
        .load          (buf_load),
        .clear         (buf_clear),
        .target        (branch_target_address_i),
        .pending_addr  (pending_addr),
        .pending_valid (pending_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_reg <= PC_OFF;
            pc_reg    <= RESET_VECTOR;
            ce_reg    <= ChipDisable;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ce_reg    <= ce_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ce_next    = ce_reg;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;

        case (state_reg)
            PC_OFF: begin
                // pc already holds the reset vector, so enabling fetch is all
                // that is needed; flush/branch are ignored until running.
                state_next = PC_RUN;
                ce_next    = ChipEnable;
            end
            default: begin
                if (flush_i) begin
                    pc_next    = new_pc_i;
                    buf_clear  = 1'b1;
                    state_next = PC_RUN;
                end else if (branch_flag_i == Branch && advance) begin
                    pc_next    = branch_target_address_i;
                    buf_clear  = 1'b1;
                    state_next = PC_RUN;
                end else if (branch_flag_i == Branch) begin
                    buf_load   = 1'b1;
                    state_next = PC_HELD;
                end else if (state_reg == PC_HELD && advance) begin
                    pc_next    = pending_addr;
                    buf_clear  = 1'b1;
                    state_next = PC_RUN;
                end else if (state_reg == PC_RUN && advance) begin
                    // Natural modulo-2^ADDR_W wrap.
                    pc_next = pc_reg + PcStep;
                end
            end
        endcase
    end

    assign pc                 = pc_reg;
    assign ce                 = ce_reg;
    assign redirect_pending_o = pending_valid;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test-plan sequences followed by randomized stimulus,
// compared every cycle against a behavioural fetch-address model.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  stall_i = '0;
    logic        if_ready_i = 1'b1;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pending_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit          m_on;
    logic [31:0] m_pc;
    bit          m_pend_v;
    logic [31:0] m_pend;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk                     (clk),
        .rst                     (rst_n),
        .stall_i                 (stall_i),
        .if_ready_i              (if_ready_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .flush_i                 (flush_i),
        .new_pc_i                (new_pc_i),
        .pc                      (pc),
        .ce                      (ce),
        .redirect_pending_o      (redirect_pending_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_on     = 0;
        m_pc     = RV;
        m_pend_v = 0;
        m_pend   = '0;
    endtask

    // One clock edge: advance the model from the inputs seen at the edge,
    // then compare all outputs shortly after the edge.
    task automatic step(input string tag);
        bit adv;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_on) begin
            m_on = 1;
        end else begin
            adv = !stall_i[0] && if_ready_i;
            if (flush_i) begin
                m_pc = new_pc_i; m_pend_v = 0;
            end else if (branch_flag_i && adv) begin
                m_pc = branch_target_address_i; m_pend_v = 0;
            end else if (branch_flag_i) begin
                m_pend = branch_target_address_i; m_pend_v = 1;
            end else if (adv) begin
                m_pc = m_pend_v ? m_pend : m_pc + 32'd4;
                m_pend_v = 0;
            end
        end
        #1;
        $display("[TB] %s rst=%0b st=%0b rdy=%0b br=%0b fl=%0b -> pc=%08h ce=%0b pend=%0b",
                 tag, rst_n, stall_i[0], if_ready_i, branch_flag_i, flush_i, pc, ce, redirect_pending_o);
        check_val({tag, ".pc"}, pc, m_pc);
        check_val({tag, ".ce"}, {31'd0, ce}, {31'd0, m_on});
        check_val({tag, ".pend"}, {31'd0, redirect_pending_o}, {31'd0, m_pend_v});
    endtask

    task automatic set_in(input logic [5:0] st, input logic rdy, input logic br,
                          input logic [31:0] tgt, input logic fl, input logic [31:0] npc);
        @(negedge clk);
        stall_i = st; if_ready_i = rdy; branch_flag_i = br;
        branch_target_address_i = tgt; flush_i = fl; new_pc_i = npc;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_val("rst.ce", {31'd0, ce}, 32'd0);
        check_val("rst.pc", pc, RV);
        check_val("rst.pend", {31'd0, redirect_pending_o}, 32'd0);
        for (int i = 0; i < 3; i++) step("reset");

        // Reset release.
        @(negedge clk); rst_n = 1'b1;
        step("release");
        check_val("first_fetch", pc, 32'h8000_0000);
        step("seq1");
        check_val("seq1_pc", pc, 32'h8000_0004);
        step("seq2");
        check_val("seq2_pc", pc, 32'h8000_0008);

        // Branch while running.
        set_in(6'b0, 1, 1, 32'h8000_1000, 0, 0);
        step("br_run");
        check_val("br_run_pc", pc, 32'h8000_1000);
        set_in(6'b0, 1, 0, 0, 0, 0);
        step("br_run_next");
        check_val("br_run_next_pc", pc, 32'h8000_1004);

        // Branch during stall.
        set_in(6'b000001, 1, 1, 32'h8000_2000, 0, 0);
        step("br_stall0");
        check_val("br_stall_hold", pc, 32'h8000_1004);
        check_val("br_stall_pend", {31'd0, redirect_pending_o}, 32'd1);
        set_in(6'b000001, 1, 0, 0, 0, 0);
        step("br_stall1");
        step("br_stall2");
        check_val("br_stall2_pend", {31'd0, redirect_pending_o}, 32'd1);
        set_in(6'b0, 1, 0, 0, 0, 0);
        step("stall_rel");
        check_val("stall_rel_pc", pc, 32'h8000_2000);
        check_val("stall_rel_pend", {31'd0, redirect_pending_o}, 32'd0);

        // Flush beats branch while memory not ready.
        set_in(6'b0, 0, 1, 32'h8000_3000, 1, 32'h8000_0180);
        step("flush");
        check_val("flush_pc", pc, 32'h8000_0180);
        check_val("flush_pend", {31'd0, redirect_pending_o}, 32'd0);

        // Wrap through the top of the address space.
        set_in(6'b0, 1, 1, 32'hFFFF_FFF8, 0, 0);
        step("wrap0");
        set_in(6'b0, 1, 0, 0, 0, 0);
        step("wrap1");
        check_val("wrap_fc", pc, 32'hFFFF_FFFC);
        step("wrap2");
        check_val("wrap_00", pc, 32'h0000_0000);

        // Asynchronous reset while HELD.
        set_in(6'b000001, 1, 1, 32'h8000_4000, 0, 0);
        step("held");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async.ce", {31'd0, ce}, 32'd0);
        check_val("async.pc", pc, RV);
        check_val("async.pend", {31'd0, redirect_pending_o}, 32'd0);
        branch_flag_i = 1'b0; stall_i = '0;
        step("async_hold");
        @(negedge clk); rst_n = 1'b1;
        step("async_release");

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            stall_i                 = 6'($urandom);
            stall_i[0]              = ($urandom_range(0, 3) == 0);
            if_ready_i              = ($urandom_range(0, 3) != 0);
            branch_flag_i           = ($urandom_range(0, 4) == 0);
            branch_target_address_i = $urandom;
            flush_i                 = ($urandom_range(0, 19) == 0);
            new_pc_i                = $urandom;
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the OpenMips fetch stage.
- Drives the fetch address and chip-enable to instruction memory.
- Honours a pipeline stall vector and a memory-ready handshake.
- Redirects on branch or exception flush. A branch that arrives while fetch is held is buffered and applied on the next advance, never lost.

Parameters:
ADDR_W, 32, width of PC and of all target addresses
RESET_VECTOR, 32'h80000000, first fetch address after reset release
INST_BYTES, 4, sequential increment in bytes; power of two, at least 1
STALL_W, 6, width of the stall vector; bit 0 is the PC-stage stall

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
stall_i  in  STALL_W  pipeline stall vector; only bit 0 affects this block
if_ready_i  in  1  instruction memory accepts the current fetch this cycle
branch_flag_i  in  1  branch taken, qualified by ID stage
branch_target_address_i  in  ADDR_W  branch destination
flush_i  in  1  exception/eret flush, highest priority
new_pc_i  in  ADDR_W  flush destination
pc  out  ADDR_W  current fetch address
ce  out  1  fetch enable to instruction memory
redirect_pending_o  out  1  a buffered branch target is waiting

Behaviour:
- Reset (rst=0, asynchronous):
  - ce=0, pc=RESET_VECTOR.
  - Pending register cleared, redirect_pending_o=0.
  - state=OFF.
- States:
  - OFF: ce=0. First rising edge with rst=1 moves to RUN and sets ce=1. pc holds RESET_VECTOR, so the first fetch is the reset vector.
  - RUN: no pending redirect.
  - HELD: redirect_pending_o=1.
- advance = ce & ~stall_i[0] & if_ready_i.
- Next-pc priority, evaluated each edge in RUN/HELD:
  1. flush_i=1: pc<=new_pc_i whether or not advance is true. Pending is cleared; go to RUN.
  2. branch_flag_i=1 and advance: pc<=branch_target_address_i. Pending is cleared; go to RUN.
  3. branch_flag_i=1 and not advance: pending<=branch_target_address_i; go to HELD. pc unchanged.
  4. HELD and advance: pc<=pending. Pending is cleared; go to RUN.
  5. RUN and advance: pc<=pc+INST_BYTES, wrapping modulo 2^ADDR_W (0xFFFFFFFC -> 0x00000000 at defaults).
  6. Otherwise: pc holds.
- Branch while already HELD: the new target overwrites pending. If advance is also true, rule 2 applies.
- Flush in OFF is ignored. ce never deasserts except on reset.
- Latency: a redirect is visible on pc one cycle after the qualifying edge; there are no bubbles beyond that.
- Reset asserted mid-operation forces all reset values immediately, without waiting for clk.
- No alignment checking. Low address bits pass through unmodified.
- Outputs are registered only; no combinational path from inputs to pc or ce.

Decomposition:
- Shared package (defines.v) holds:
  - RstEnable, redefined as 1'b0;
  - ChipEnable/ChipDisable;
  - Branch/NotBranch;
  - InstAddrBus;
  - the default reset vector;
  - the 2-bit state encodings PC_OFF, PC_RUN, PC_HELD.
- One natural sub-module, pc_redirect_buf: pending target register plus valid bit, with load/clear/overwrite.
- All priority logic stays in pc_gen.

Test Plan:
- Reset release: hold rst=0 for 3 cycles, then release, with stall=0 and ready=1.
  - ce rises one edge after release; pc=0x80000000 on that cycle.
  - Next edges: 0x80000004, 0x80000008.
- Branch while running: at pc=0x80000008, pulse branch_flag_i with target 0x80001000.
  - Next pc=0x80001000, then 0x80001004; redirect_pending_o stays 0.
- Branch during stall: stall_i=6'b000001 for 3 cycles, with a branch to 0x80002000 in the first stalled cycle.
  - pc holds and redirect_pending_o=1 throughout the stall.
  - On release, pc=0x80002000 and pending clears.
- Flush beats branch: assert flush_i with new_pc_i=0x80000180 together with a branch to 0x80003000 while if_ready_i=0.
  - pc=0x80000180 next cycle; no pending target remains.
- Wrap: force the sequence through 0xFFFFFFF8.
  - pc goes 0xFFFFFFFC, then 0x00000000.
- Async reset mid-HELD: drop rst between edges.
  - ce=0, pc=0x80000000 and redirect_pending_o=0 before the next clk edge.
